// File: rtl/dsp_seq.sv
// dsp_seq: sequences requests onto an external multi-cycle DSP and queues results in a 2-entry FIFO.
// Build with DSP_SEQ_ERR_EN defined to answer mode-3 requests with an error response instead of issuing them.
module dsp_seq #(
    parameter int WIDTH      = 33,
    parameter int SHIFT_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [WIDTH-1:0]      req_a,
    input  logic [WIDTH-1:0]      req_b,
    input  logic [2*WIDTH-1:0]    req_c,
    input  logic [1:0]            req_mode,
    input  logic                  req_mac,
    input  logic [SHIFT_BITS-1:0] req_shift_amount,
    input  logic                  req_shift_dir,
    output logic                  dsp_start,
    output logic [WIDTH-1:0]      dsp_aa,
    output logic [WIDTH-1:0]      dsp_bb,
    output logic [2*WIDTH-1:0]    dsp_cc,
    output logic [1:0]            dsp_mode,
    output logic                  dsp_mac,
    output logic [SHIFT_BITS-1:0] dsp_shift_amount,
    output logic                  dsp_shift_dir,
    input  logic [2*WIDTH-1:0]    dsp_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2*WIDTH-1:0]    rsp_data,
    output logic                  rsp_acc,
    output logic                  rsp_err
);
    localparam int DW = 2 * WIDTH;
`ifdef DSP_SEQ_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, HOLD, ISSUE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0]      a;
        logic [WIDTH-1:0]      b;
        logic [DW-1:0]         c;
        logic [1:0]            mode;
        logic                  mac;
        logic [SHIFT_BITS-1:0] shamt;
        logic                  dir;
    } op_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          acc;
        logic          err;
    } rsp_t;

    state_t         state_q, state_d, nxt;
    logic [1:0]     cnt_q, cnt_d, occ_q, occ_d;
    logic           rd_q, rd_d, wr_q, wr_d;
    rsp_t [1:0]     mem_q, mem_d;
    rsp_t           head;
    op_t            op_q, op_d;
    logic           chain_q, chain_d;
    logic           req_ready_q, req_ready_d;
    logic           start_q, start_d;
    logic           mac_q, mac_d;
    logic [1:0]     mode_q, mode_d;
    logic           last, is_err, accept, push, pop;

    function automatic logic [1:0] last_cnt(input logic [1:0] mode);
        return mode == 2'd1 ? 2'd1 : mode == 2'd2 ? 2'd3 : 2'd0;
    endfunction

    function automatic logic err_op(input logic [1:0] mode);
        return ERR_EN && mode == 2'd3;
    endfunction

    always_comb begin
        last    = state_q == ISSUE && cnt_q == last_cnt(op_q.mode);
        is_err  = err_op(op_q.mode);
        accept  = req_valid && req_ready_q;
        push    = last;
        pop     = occ_q != 2'd0 && rsp_ready;
        occ_d   = occ_q + {1'b0, push} - {1'b0, pop};
        rd_d    = rd_q ^ pop;
        wr_d    = wr_q ^ push;
        mem_d   = mem_q;
        // chain_q stays high through every cycle of an op that directly follows a mac op
        if (push)
            mem_d[wr_q] = '{data: is_err ? '0 : dsp_out, acc: op_q.mac && chain_q && !is_err, err: is_err};
        nxt     = accept ? (occ_d <= 2'd1 ? ISSUE : HOLD) : IDLE;
        state_d = state_q == HOLD ? (occ_d <= 2'd1 ? ISSUE : HOLD)
                : (state_q == IDLE || last) ? nxt : ISSUE;
        cnt_d   = (state_q == ISSUE && !last) ? cnt_q + 2'd1 : 2'd0;
        op_d    = accept ? '{a: req_a, b: req_b, c: req_c, mode: req_mode, mac: req_mac,
                             shamt: req_shift_amount, dir: req_shift_dir} : op_q;
        chain_d = state_q != ISSUE ? 1'b0 : last ? op_q.mac && !is_err : chain_q;
        req_ready_d = state_d == IDLE || (state_d == ISSUE && cnt_d == last_cnt(op_d.mode));
        start_d = state_d == ISSUE && cnt_d == 2'd0 && !err_op(op_d.mode);
        mac_d   = state_d == ISSUE && op_d.mac && !err_op(op_d.mode);
        mode_d  = state_d == ISSUE ? op_d.mode : 2'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            occ_q       <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            mem_q       <= '0;
            op_q        <= '0;
            chain_q     <= 1'b0;
            req_ready_q <= 1'b1;
            start_q     <= 1'b0;
            mac_q       <= 1'b0;
            mode_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            occ_q       <= occ_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            mem_q       <= mem_d;
            op_q        <= op_d;
            chain_q     <= chain_d;
            req_ready_q <= req_ready_d;
            start_q     <= start_d;
            mac_q       <= mac_d;
            mode_q      <= mode_d;
        end
    end

    assign head             = mem_q[rd_q];
    assign req_ready        = req_ready_q;
    assign dsp_start        = start_q;
    assign dsp_mac          = mac_q;
    assign dsp_mode         = mode_q;
    assign dsp_aa           = op_q.a;
    assign dsp_bb           = op_q.b;
    assign dsp_cc           = op_q.c;
    assign dsp_shift_amount = op_q.shamt;
    assign dsp_shift_dir    = op_q.dir;
    assign rsp_valid        = occ_q != 2'd0;
    assign rsp_data         = head.data;
    assign rsp_acc          = head.acc;
    assign rsp_err          = ERR_EN & head.err;
endmodule

// File: doc/dsp_seq.md
DSP_SEQ -- requirements
Module: dsp_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 33: operand width of the driven DSP multiplier.
REQ-002 SHALL have parameter SHIFT_BITS, default 2: width of the accumulator shift-amount field.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports req_valid in 1 / req_ready out 1: request handshake, transfer when both are high.
REQ-006 SHALL have request payload inputs: req_a and req_b WIDTH, req_c 2*WIDTH, req_mode 2, req_mac 1, req_shift_amount SHIFT_BITS, req_shift_dir 1.
REQ-007 SHALL have DSP-side outputs: dsp_start 1, dsp_aa and dsp_bb WIDTH, dsp_cc 2*WIDTH, dsp_mode 2, dsp_mac 1, dsp_shift_amount SHIFT_BITS, dsp_shift_dir 1.
REQ-008 SHALL have port dsp_out  input  2*WIDTH  combinational DSP result.
REQ-009 SHALL have response ports: rsp_valid out 1, rsp_ready in 1, rsp_data out 2*WIDTH, rsp_acc out 1 (accumulation occurred), rsp_err out 1.

Function
REQ-010 SHALL hold one operation register, loaded on a req handshake; all dsp_* payload outputs SHALL be driven from it.
REQ-011 SHALL use an issue length N of 1 for mode 0, 2 for mode 1, 4 for mode 2, and 1 for mode 3 (when forwarded).
REQ-012 SHALL implement states IDLE, HOLD and ISSUE, with a cycle counter cnt in the range 0..N-1.
REQ-013 SHALL include a 2-entry response FIFO of {data, acc, err}; its occupancy count is occ, and rsp_valid = (occ != 0).
REQ-014 After acceptance, the block SHALL enter ISSUE if the next-cycle value of occ is at most 1, and HOLD otherwise; HOLD SHALL move to ISSUE as soon as occ is at most 1.
REQ-015 SHALL assert dsp_start only in ISSUE cycle cnt=0, for exactly one cycle per operation.
REQ-016 SHALL drive dsp_mac equal to the operation's mac bit in all ISSUE cycles, and 0 otherwise.
REQ-017 SHALL capture dsp_out into the FIFO at the edge that ends ISSUE cycle cnt=N-1.
REQ-018 SHALL set rsp_acc = 1 only when the operation's mac bit is 1 and the previous cycle was the last ISSUE cycle of an operation whose mac bit was 1 (back-to-back chain).
REQ-019 SHALL drive req_ready = 1 in IDLE, and in ISSUE when cnt = N-1; req_ready SHALL be 0 in HOLD.
REQ-020 SHALL support back-to-back operation: a request accepted in the last ISSUE cycle SHALL start issuing in the next cycle without a bubble, provided occ permits.
REQ-021 Latency: for a request accepted in cycle 0 with an empty FIFO, rsp_valid SHALL rise in cycle N+1.
REQ-022 SHALL pop the FIFO on rsp_valid && rsp_ready, and SHALL allow a push and a pop in the same cycle.
REQ-023 SHALL keep ops in FIFO order; the FIFO SHALL never overflow.
REQ-024 When not in ISSUE, dsp_start and dsp_mac SHALL be 0 and dsp_mode SHALL be 0.

Reset
REQ-025 When rst is asserted, including mid-ISSUE, the block SHALL: go to IDLE; clear occ and cnt; zero the operation register and the mac-chain flag; hold all outputs at 0 except req_ready.
REQ-026 req_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-027 With macro DSP_SEQ_ERR_EN defined, a mode-3 request SHALL be accepted but never issued (no dsp_start), and SHALL push {0, 0, 1} into the FIFO once occ is at most 1.
REQ-028 Without DSP_SEQ_ERR_EN, a mode-3 request SHALL be issued as a 1-cycle operation, and rsp_err SHALL be tied to 0.

Verification
REQ-029 Mode 0, a=3, b=5, c=7, accepted in cycle 0: dsp_start high in cycle 1 only; rsp_valid in cycle 2 with rsp_data=22 and rsp_acc=0.
REQ-030 Mode 2, a=0x1_0000_0000, b=3, c=0: 4 ISSUE cycles with dsp_start in the first only; rsp_data=0x3_0000_0000 in cycle 5.
REQ-031 Two back-to-back mode-1 ops with mac=1 (first a=2, b=3, c=10; second a=4, b=5, shift 0): responses are 16 with acc=0, then 36 with acc=1; inserting an idle gap gives the second response = c + 20 with acc=0.
REQ-032 With rsp_ready=0 and three mode-0 requests: the third stays in HOLD with no dsp_start and req_ready=0; one pop lets it issue the next cycle.
REQ-033 Assert rst in cycle 2 of a mode-2 issue: dsp_start, dsp_mac and rsp_valid are 0 immediately; req_ready=1 after release; no stale response appears.
REQ-034 Mode-3 request: with DSP_SEQ_ERR_EN, rsp_err=1 and rsp_data=0 with no dsp_start; without it, exactly one dsp_start pulse and rsp_err=0.
